// File: rtl/instmem_loadable.sv
// Run-time loadable instruction memory.
// Word-organised, byte-addressed (little-endian) store. It is programmed through a
// valid/ready load stream and serves registered fetches with alignment and range
// fault reporting. A sticky flag marks that a good fetch returned the SENTINEL word.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_start        pulse: begin (re)programming (ignored while loading)
//   load_valid/data/last, load_ready   load beat stream
//   load_count        number of words currently loaded
//   busy              high while loading
//   fetch_req/addr    fetch request, byte address
//   fetch_valid/instr/fault  fetch response, one cycle after the request
//   last_instr_flag   sticky end-of-program indication
module instmem_loadable #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [DATA_W-1:0] SENTINEL    = '1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_start,
  input  logic                               load_valid,
  input  logic [DATA_W-1:0]                  load_data,
  input  logic                               load_last,
  output logic                               load_ready,
  output logic [$clog2(DEPTH_WORDS+1)-1:0]   load_count,
  output logic                               busy,
  input  logic                               fetch_req,
  input  logic [ADDR_W-1:0]                  fetch_addr,
  output logic                               fetch_valid,
  output logic [DATA_W-1:0]                  instr,
  output logic                               fault,
  output logic                               last_instr_flag
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(DEPTH_WORDS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              ready_nxt;
  logic              busy_nxt;
  logic              fvalid_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic              fault_nxt;
  logic              flag_nxt;
  logic              wr_en_c;

  logic [IDX_W-1:0]  fetch_idx_c;
  logic              fetch_bad_c;
  logic              fetch_hit_c;
  logic [DATA_W-1:0] rd_word_c;

  // Fetch decode: word index, fault conditions, and the word that would be returned.
  always_comb begin
    fetch_idx_c = fetch_addr[IDX_W+1:2];
    fetch_bad_c = (state != ST_RUN) || (fetch_addr[1:0] != 2'b00) ||
                  ((fetch_addr >> 2) >= ADDR_W'(DEPTH_WORDS));
    fetch_hit_c = CNT_W'(fetch_idx_c) < load_count;
    // Words at or beyond load_count read as SENTINEL, so stale data stays unreachable.
    rd_word_c   = (fetch_bad_c || !fetch_hit_c) ? SENTINEL : mem[fetch_idx_c];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    count_nxt  = load_count;
    flag_nxt   = last_instr_flag;
    wr_en_c    = 1'b0;
    fvalid_nxt = fetch_req;
    instr_nxt  = instr;
    fault_nxt  = fault;

    if (fetch_req) begin
      instr_nxt = rd_word_c;
      fault_nxt = fetch_bad_c;
      if (!fetch_bad_c && (rd_word_c == SENTINEL)) begin
        flag_nxt = 1'b1;
      end
    end

    // Entry to LOAD is evaluated after the fetch, so it clears a flag set on the same edge.
    case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt = ST_LOAD;
          count_nxt = '0;
          flag_nxt  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_valid && load_ready) begin
          wr_en_c   = 1'b1;
          count_nxt = load_count + CNT_W'(1);
          if (load_last || (load_count == CNT_W'(DEPTH_WORDS - 1))) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_nxt = ST_LOAD;
          count_nxt = '0;
          flag_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase

    busy_nxt  = (state_nxt == ST_LOAD);
    ready_nxt = (state_nxt == ST_LOAD) && (count_nxt < CNT_W'(DEPTH_WORDS));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      load_count      <= '0;
      load_ready      <= 1'b0;
      busy            <= 1'b0;
      fetch_valid     <= 1'b0;
      instr           <= SENTINEL;
      fault           <= 1'b0;
      last_instr_flag <= 1'b0;
    end else begin
      state           <= state_nxt;
      load_count      <= count_nxt;
      load_ready      <= ready_nxt;
      busy            <= busy_nxt;
      fetch_valid     <= fvalid_nxt;
      instr           <= instr_nxt;
      fault           <= fault_nxt;
      last_instr_flag <= flag_nxt;
    end
  end

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[load_count[IDX_W-1:0]] <= load_data;
    end
  end

endmodule

// File: tb/tb_instmem_loadable.sv
// Bench for instmem_loadable: directed stimulus, a behavioural model checked every
// cycle, and literal expectations at key points of the program.
module tb_instmem_loadable;

  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] S     = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_valid, load_last, load_ready, busy;
  logic [31:0] load_data;
  logic [5:0]  load_count;
  logic        fetch_req, fetch_valid, fault, last_instr_flag;
  logic [31:0] fetch_addr, instr;

  instmem_loadable dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_count(load_count),
    .busy(busy), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .instr(instr), .fault(fault),
    .last_instr_flag(last_instr_flag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 = idle, 1 = loading, 2 = running.
  logic [31:0] m_mem [DEPTH];
  int          m_count, m_st, pre;
  bit          m_valid, m_fault, m_flag;
  logic [31:0] m_instr, widx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_count = 0; m_valid = 0; m_instr = S; m_fault = 0; m_flag = 0;
    end else begin
      pre     = m_st;
      m_valid = fetch_req;
      if (fetch_req) begin
        widx    = fetch_addr / 4;
        m_fault = (pre != 2) || (fetch_addr % 4 != 0) || (widx >= DEPTH);
        if (m_fault)              m_instr = S;
        else if (widx < m_count)  m_instr = m_mem[widx[4:0]];
        else                      m_instr = S;
        if (!m_fault && m_instr == S) m_flag = 1;
      end
      if (pre == 1 && load_valid && m_count < DEPTH) begin
        m_mem[m_count] = load_data;
        m_count++;
        if (load_last || m_count == DEPTH) m_st = 2;
      end
      if (load_start && pre != 1) begin
        m_st = 1; m_count = 0; m_flag = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("load_count",  32'(load_count),      32'(m_count));
      chk("load_ready",  32'(load_ready),      32'(m_st == 1 && m_count < DEPTH));
      chk("busy",        32'(busy),            32'(m_st == 1));
      chk("fetch_valid", 32'(fetch_valid),     32'(m_valid));
      chk("instr",       instr,                m_instr);
      chk("fault",       32'(fault),           32'(m_fault));
      chk("flag",        32'(last_instr_flag), 32'(m_flag));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    load_valid = 1'b1; load_data = d; load_last = l;
    step();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic fetch1(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    step();
    fetch_req = 1'b0;
  endtask

  logic        g_valid [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        g_start [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] g_data  [5] = '{32'hA0, 32'hEE, 32'hA1, 32'hEF, 32'hA2};
  logic        g_last  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b1; load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    fetch_req = 0; fetch_addr = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_instr", instr, S);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_flag",  32'(last_instr_flag), 32'd0);
    step(); step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Fetch while idle faults.
    fetch1(32'd0);
    chk("idle_fault", 32'(fault), 32'd1);
    chk("idle_instr", instr, S);

    // Three-word program.
    load_start = 1'b1; step(); load_start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    beat(32'h00500093, 1'b0);
    beat(32'h00100113, 1'b0);
    beat(32'h002081B3, 1'b1);
    chk("prog3_count", 32'(load_count), 32'd3);
    chk("prog3_busy", 32'(busy), 32'd0);

    fetch_req = 1'b1; fetch_addr = 32'd0; step();
    chk("f0", instr, 32'h00500093);
    fetch_addr = 32'd4; step();
    chk("f4", instr, 32'h00100113);
    fetch_addr = 32'd8; step();
    chk("f8", instr, 32'h002081B3);
    chk("f8_fault", 32'(fault), 32'd0);
    chk("f8_flag", 32'(last_instr_flag), 32'd0);
    fetch_req = 1'b0; step();
    chk("idle_valid", 32'(fetch_valid), 32'd0);
    chk("hold_instr", instr, 32'h002081B3);

    fetch1(32'd12);
    chk("f12_instr", instr, S);
    chk("f12_fault", 32'(fault), 32'd0);
    chk("f12_flag", 32'(last_instr_flag), 32'd1);
    fetch1(32'd0);
    chk("flag_sticky", 32'(last_instr_flag), 32'd1);

    fetch1(32'd6);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_instr", instr, S);
    fetch1(32'd128);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_flag", 32'(last_instr_flag), 32'd1);

    // Full-depth load without load_last.
    load_start = 1'b1; step(); load_start = 1'b0;
    chk("reload_flag", 32'(last_instr_flag), 32'd0);
    for (int i = 0; i < 32; i++) beat(32'h1000 + 32'(i), 1'b0);
    chk("full_ready", 32'(load_ready), 32'd0);
    chk("full_count", 32'(load_count), 32'd32);
    chk("full_busy", 32'(busy), 32'd0);
    beat(32'hDEAD_BEEF, 1'b0);
    chk("overflow_count", 32'(load_count), 32'd32);
    fetch1(32'd124);
    chk("f124", instr, 32'h0000101F);
    fetch1(32'd0);
    chk("f0_full", instr, 32'h00001000);

    // Gapped beats with load_start pulses while loading.
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_start = g_start[i];
      load_valid = g_valid[i]; load_data = g_data[i]; load_last = g_last[i];
      step();
    end
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    chk("gap_count", 32'(load_count), 32'd3);
    chk("gap_busy", 32'(busy), 32'd0);
    fetch1(32'd4);
    chk("gap_f4", instr, 32'h000000A1);
    fetch1(32'd12);
    chk("gap_f12_flag", 32'(last_instr_flag), 32'd1);

    // Reload request coinciding with a fetch.
    load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 32'd0;
    step();
    load_start = 1'b0; fetch_req = 1'b0;
    chk("sim_instr", instr, 32'h000000A0);
    chk("sim_fault", 32'(fault), 32'd0);
    chk("sim_count", 32'(load_count), 32'd0);
    chk("sim_busy", 32'(busy), 32'd1);
    chk("sim_flag", 32'(last_instr_flag), 32'd0);

    // Asynchronous reset mid-load.
    beat(32'hB0, 1'b0);
    beat(32'hB1, 1'b0);
    chk("pre_rst_count", 32'(load_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(load_count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(load_ready), 32'd0);
    chk("arst_instr", instr, S);
    step(); step();
    rst_n = 1'b1;
    step();
    fetch1(32'd0);
    chk("post_rst_fault", 32'(fault), 32'd1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
